// File: rtl/conv2d_pool_requant.sv
// 2x2/stride-2 max pooling with optional ReLU and rounding-shift requantization.
// Streams a CHW feature map from the producer RAM into a narrow pooled map.
module conv2d_pool_requant #(
  parameter int CHANNELS   = 16,
  parameter int IN_HEIGHT  = 32,
  parameter int IN_WIDTH   = 32,
  parameter int DATA_IN_W  = 32,
  parameter int DATA_OUT_W = 8,
  parameter int SHIFT      = 8,
  parameter int RELU_EN    = 1,
  localparam int OH     = IN_HEIGHT / 2,
  localparam int OW     = IN_WIDTH / 2,
  localparam int IN_N   = CHANNELS * IN_HEIGHT * IN_WIDTH,
  localparam int OUT_N  = CHANNELS * OH * OW,
  localparam int IN_AW  = (IN_N > 1) ? $clog2(IN_N) : 1,
  localparam int OUT_AW = (OUT_N > 1) ? $clog2(OUT_N) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [IN_AW-1:0]      input_addr,
  output logic                  input_en,
  input  logic [DATA_IN_W-1:0]  input_data,
  output logic [OUT_AW-1:0]     output_addr,
  output logic [DATA_OUT_W-1:0] output_data,
  output logic                  output_we,
  output logic                  output_en
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int YW = (OH > 1) ? $clog2(OH) : 1;
  localparam int XW = (OW > 1) ? $clog2(OW) : 1;

  localparam logic signed [DATA_IN_W:0] SAT_MAX =
    (DATA_IN_W+1)'((64'sd1 <<< (DATA_OUT_W-1)) - 64'sd1);
  localparam logic signed [DATA_IN_W:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

  state_e state_q, state_d;

  logic [CW-1:0] ch_q, ch_d;
  logic [YW-1:0] oy_q, oy_d;
  logic [XW-1:0] ox_q, ox_d;
  logic [1:0]    k_q, k_d;
  logic          last_rd;

  logic                         rd_vld_q;
  logic [1:0]                   rd_k_q;
  logic signed [DATA_IN_W-1:0]  max_q;
  logic                         out_we_q;
  logic [DATA_OUT_W-1:0]        out_data_q;
  logic [OUT_AW-1:0]            out_addr_q;
  logic [OUT_AW-1:0]            wr_idx_q;

  logic signed [DATA_IN_W-1:0]  din_s, win_max, relu_v;
  logic signed [DATA_IN_W:0]    ext_v, shr_v;
  logic [DATA_OUT_W-1:0]        q_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    oy_d    = oy_q;
    ox_d    = ox_q;
    k_d     = k_q;
    last_rd = (k_q == 2'd3) && (ox_q == XW'(OW-1)) &&
              (oy_q == YW'(OH-1)) && (ch_q == CW'(CHANNELS-1));
    case (state_q)
      S_IDLE: begin
        ch_d = '0;
        oy_d = '0;
        ox_d = '0;
        k_d  = '0;
        if (start) state_d = S_READ;
      end
      S_READ: begin
        k_d = k_q + 2'd1;
        // window walk: k innermost, then ox, oy, channel
        if (k_q == 2'd3) begin
          if (ox_q == XW'(OW-1)) begin
            ox_d = '0;
            if (oy_q == YW'(OH-1)) begin
              oy_d = '0;
              ch_d = (ch_q == CW'(CHANNELS-1)) ? '0 : ch_q + CW'(1);
            end else begin
              oy_d = oy_q + YW'(1);
            end
          end else begin
            ox_d = ox_q + XW'(1);
          end
        end
        if (last_rd) state_d = S_DRAIN;
      end
      // the only write that can land in DRAIN is the final window's
      S_DRAIN: if (out_we_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign input_en   = (state_q == S_READ);
  assign input_addr = IN_AW'(32'(ch_q) * 32'(IN_HEIGHT * IN_WIDTH)
                           + (32'(oy_q) * 32'd2 + 32'(k_q[1])) * 32'(IN_WIDTH)
                           + 32'(ox_q) * 32'd2 + 32'(k_q[0]));

  assign din_s   = input_data;
  assign win_max = (rd_k_q == 2'd0 || din_s > max_q) ? din_s : max_q;

  always_comb begin
    relu_v = (RELU_EN != 0 && win_max < 0) ? '0 : win_max;
    ext_v  = {relu_v[DATA_IN_W-1], relu_v};
  end

  // one extra bit of headroom keeps the rounding add from overflowing
  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [DATA_IN_W:0] RND = (DATA_IN_W+1)'(1) <<< (SHIFT-1);
      assign shr_v = (ext_v + RND) >>> SHIFT;
    end else begin : g_noround
      assign shr_v = ext_v;
    end
  endgenerate

  always_comb begin
    if (shr_v > SAT_MAX)      q_val = SAT_MAX[DATA_OUT_W-1:0];
    else if (shr_v < SAT_MIN) q_val = SAT_MIN[DATA_OUT_W-1:0];
    else                      q_val = shr_v[DATA_OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_q       <= '0;
      oy_q       <= '0;
      ox_q       <= '0;
      k_q        <= '0;
      rd_vld_q   <= 1'b0;
      rd_k_q     <= '0;
      max_q      <= '0;
      out_we_q   <= 1'b0;
      out_data_q <= '0;
      out_addr_q <= '0;
      wr_idx_q   <= '0;
    end else begin
      ch_q       <= ch_d;
      oy_q       <= oy_d;
      ox_q       <= ox_d;
      k_q        <= k_d;
      rd_vld_q   <= input_en;
      rd_k_q     <= k_q;
      out_we_q   <= 1'b0;
      out_data_q <= '0;
      if (rd_vld_q) max_q <= win_max;
      if (state_q == S_IDLE) wr_idx_q <= '0;
      if (rd_vld_q && rd_k_q == 2'd3) begin
        out_we_q   <= 1'b1;
        out_data_q <= q_val;
        out_addr_q <= wr_idx_q;
        wr_idx_q   <= wr_idx_q + OUT_AW'(1);
      end
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign output_we   = out_we_q;
  assign output_en   = out_we_q;
  assign output_data = out_data_q;
  assign output_addr = out_addr_q;

endmodule

// File: tb/tb_conv2d_pool_requant.sv
// Bench for conv2d_pool_requant: four configurations checked every cycle
// against a window-level timing/arithmetic model plus literal expectations.
module tb_conv2d_pool_requant;

  function automatic int cf_c(int g);    return (g == 3) ? 2 : 1;                endfunction
  function automatic int cf_h(int g);    return (g == 3) ? 5 : 4;                endfunction
  function automatic int cf_w(int g);    return (g == 3) ? 5 : 4;                endfunction
  function automatic int cf_sh(int g);   return (g == 2) ? 4 : 0;                endfunction
  function automatic int cf_relu(int g); return (g == 0 || g == 3) ? 1 : 0;      endfunction
  function automatic int n_win(int g);   return cf_c(g) * (cf_h(g)/2) * (cf_w(g)/2); endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  st = '0;
  logic [3:0]  by, dn, ien, owe, oen;
  logic [63:0] iad_f, oad_f;
  logic [31:0] odat_f;

  int mem [4][64];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int C   = cf_c(g);
    localparam int H   = cf_h(g);
    localparam int W   = cf_w(g);
    localparam int IAW = $clog2(C*H*W);
    localparam int OAW = $clog2(C*(H/2)*(W/2));
    logic [IAW-1:0] ia;
    logic [OAW-1:0] oa;
    logic [7:0]     od;
    logic [31:0]    rd_q;

    conv2d_pool_requant #(
      .CHANNELS(C), .IN_HEIGHT(H), .IN_WIDTH(W), .DATA_IN_W(32),
      .DATA_OUT_W(8), .SHIFT(cf_sh(g)), .RELU_EN(cf_relu(g))
    ) u_dut (
      .clk(clk), .rst(rst), .start(st[g]), .busy(by[g]), .done(dn[g]),
      .input_addr(ia), .input_en(ien[g]), .input_data(rd_q),
      .output_addr(oa), .output_data(od), .output_we(owe[g]), .output_en(oen[g])
    );

    assign iad_f[g*16 +: 16] = 16'(ia);
    assign oad_f[g*16 +: 16] = 16'(oa);
    assign odat_f[g*8 +: 8]  = od;

    always @(posedge clk) if (ien[g]) rd_q <= mem[g][ia];
  end

  // Model: cycle index of each accepted start (-1 when idle or after reset).
  int cyc = 0;
  int S [4] = '{-1, -1, -1, -1};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int g = 0; g < 4; g++) S[g] = -1;
    end else begin
      cyc = cyc + 1;
      for (int g = 0; g < 4; g++)
        if (st[g] && (S[g] < 0 || (cyc - 1 - S[g]) > 4*n_win(g) + 2)) S[g] = cyc;
    end
  end

  function automatic int win_base(int g, int w);
    int h = cf_h(g);
    int wd = cf_w(g);
    int per = (h/2) * (wd/2);
    int c = w / per;
    int oy = (w % per) / (wd/2);
    int ox = w % (wd/2);
    return c*h*wd + 2*oy*wd + 2*ox;
  endfunction

  function automatic int rd_addr(int g, int rel);
    int k = rel % 4;
    return win_base(g, rel/4) + (k/2)*cf_w(g) + (k%2);
  endfunction

  function automatic int model_out(int g, int w);
    int b = win_base(g, w);
    int wd = cf_w(g);
    int offs [4] = '{0, 1, wd, wd+1};
    longint m = mem[g][b];
    for (int i = 1; i < 4; i++) if (longint'(mem[g][b+offs[i]]) > m) m = mem[g][b+offs[i]];
    if (cf_relu(g) != 0 && m < 0) m = 0;
    if (cf_sh(g) > 0) m = (m + (64'sd1 <<< (cf_sh(g)-1))) >>> cf_sh(g);
    if (m > 127) m = 127;
    if (m < -128) m = -128;
    return int'(m);
  endfunction

  int n_chk = 0;
  int n_pass = 0;
  int wr [4][8];
  int nwr [4] = '{0, 0, 0, 0};
  int ndone [4] = '{0, 0, 0, 0};
  int nrd3 = 0;
  int nbad3 = 0;

  task automatic chk(input string name, input int g, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s dut%0d cyc %0d: got %0d expected %0d", name, g, cyc, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      int  n = n_win(g);
      int  rel = cyc - S[g];
      bit  act = (S[g] >= 0) && (rel <= 4*n + 2);
      bit  e_en = act && rel < 4*n;
      bit  e_we = act && rel >= 5 && ((rel-5) % 4 == 0) && ((rel-5)/4 < n);
      int  dat = $signed(odat_f[g*8 +: 8]);
      int  oad = int'(oad_f[g*16 +: 16]);
      chk("busy", g, by[g], act);
      chk("done", g, dn[g], act && rel == 4*n + 2);
      chk("input_en", g, ien[g], e_en);
      if (e_en) chk("input_addr", g, iad_f[g*16 +: 16], rd_addr(g, rel));
      chk("output_we", g, owe[g], e_we);
      chk("output_en", g, oen[g], e_we);
      chk("output_data", g, dat, e_we ? model_out(g, (rel-5)/4) : 0);
      if (e_we) chk("output_addr", g, oad, (rel-5)/4);
      if (owe[g] && oad < 8) begin
        wr[g][oad] = dat;
        nwr[g]++;
      end
      if (dn[g]) ndone[g]++;
    end
    if (ien[3]) begin
      int p = int'(iad_f[48 +: 16]) % 25;
      nrd3++;
      if (p/5 == 4 || p%5 == 4) nbad3++;
    end
  endtask

  task automatic pulse_start(input logic [3:0] m);
    st = m;
    tick();
    st = '0;
  endtask

  task automatic wait_done(input int g, input int lim);
    bit seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      tick();
      if (dn[g]) seen = 1'b1;
    end
    chk("done_timeout", g, seen, 1);
  endtask

  task automatic set_win(input int g, input int w, input int a, input int b, input int c, input int d);
    int base = 2*(w/2)*4 + 2*(w%2);
    mem[g][base]   = a;
    mem[g][base+1] = b;
    mem[g][base+4] = c;
    mem[g][base+5] = d;
  endtask

  task automatic clear_wr(input int g);
    for (int i = 0; i < 8; i++) wr[g][i] = -999;
    nwr[g] = 0;
  endtask

  task automatic check_map0(input string tag);
    chk({tag, "_w0"}, 0, wr[0][0], 5);
    chk({tag, "_w1"}, 0, wr[0][1], 7);
    chk({tag, "_w2"}, 0, wr[0][2], 13);
    chk({tag, "_w3"}, 0, wr[0][3], 15);
    chk({tag, "_nwr"}, 0, nwr[0], 4);
  endtask

  initial begin
    int nd;
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 64; i++) mem[g][i] = 0;
      clear_wr(g);
    end
    for (int i = 0; i < 16; i++) mem[0][i] = i;
    set_win(1, 0, -5, -3, -9, -1);
    set_win(1, 1, 5000, -2, 17, 4);
    set_win(1, 2, -5000, -6000, -7000, -8000);
    set_win(1, 3, 100, 100, 100, 100);
    set_win(2, 0, 24, -3, 10, 0);
    set_win(2, 1, 23, 22, -100, 5);
    set_win(2, 2, -24, -30, -40, -50);
    set_win(2, 3, 7, 6, 5, -1);
    for (int i = 0; i < 50; i++) begin
      int p = i % 25;
      mem[3][i] = ((i*37) % 101) - 50;
      if (p/5 == 4 || p%5 == 4) mem[3][i] = 1000;
    end

    chk("pin_model_w0", 0, model_out(0, 0), 5);
    chk("pin_model_w3", 0, model_out(0, 3), 15);
    chk("pin_model_neg", 1, model_out(1, 0), -1);
    chk("pin_model_rnd", 2, model_out(2, 1), 1);

    repeat (3) tick();
    rst = 1'b1;
    tick();

    // all configurations at once; dut0 also gets a start while busy
    pulse_start(4'hF);
    repeat (6) tick();
    pulse_start(4'h1);
    wait_done(0, 40);
    check_map0("runA");
    chk("runA_ndone", 0, ndone[0], 1);
    clear_wr(0);

    tick();
    pulse_start(4'h1);
    wait_done(0, 40);
    check_map0("runB");
    chk("runB_ndone", 0, ndone[0], 2);

    for (int i = 0; i < 60 && by != '0; i++) tick();
    chk("idle_timeout", 0, by, 0);
    chk("relu0_neg", 1, wr[1][0], -1);
    chk("sat_pos", 1, wr[1][1], 127);
    chk("sat_neg", 1, wr[1][2], -128);
    chk("plain", 1, wr[1][3], 100);
    chk("rnd_24", 2, wr[2][0], 2);
    chk("rnd_23", 2, wr[2][1], 1);
    chk("rnd_m24", 2, wr[2][2], -1);
    chk("rnd_7", 2, wr[2][3], 0);
    chk("odd_nwr", 3, nwr[3], 8);
    chk("odd_nrd", 3, nrd3, 32);
    chk("odd_edge_reads", 3, nbad3, 0);
    chk("odd_ndone", 3, ndone[3], 1);
    for (int i = 0; i < 8; i++) chk("odd_map", 3, wr[3][i], model_out(3, i));

    // abort in the 10th READ cycle
    clear_wr(0);
    pulse_start(4'h1);
    repeat (9) tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", 0, by[0], 0);
    chk("rst_done", 0, dn[0], 0);
    chk("rst_input_en", 0, ien[0], 0);
    chk("rst_input_addr", 0, iad_f[15:0], 0);
    chk("rst_output_we", 0, owe[0], 0);
    chk("rst_output_en", 0, oen[0], 0);
    chk("rst_output_data", 0, odat_f[7:0], 0);
    chk("rst_output_addr", 0, oad_f[15:0], 0);
    nd = ndone[0];
    repeat (3) tick();
    rst = 1'b1;
    repeat (5) tick();
    chk("abort_no_done", 0, ndone[0], nd);

    clear_wr(0);
    pulse_start(4'h1);
    wait_done(0, 40);
    check_map0("runD");

    set_win(0, 0, -5, -3, -9, -1);
    set_win(0, 1, 5000, 1, 2, 3);
    set_win(0, 2, -7, -8, -9, -10);
    set_win(0, 3, 40, 41, 42, 43);
    clear_wr(0);
    tick();
    pulse_start(4'h1);
    wait_done(0, 40);
    chk("relu1_neg", 0, wr[0][0], 0);
    chk("relu1_sat", 0, wr[0][1], 127);
    chk("relu1_neg2", 0, wr[0][2], 0);
    chk("relu1_pos", 0, wr[0][3], 43);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
